banco_registradores_param: RTL and testbench

- Parametrised multi-read-port register file for the 8-bit processor datapath, generalising the 8x8 two-read-port bank.
- Adds async active-low reset, write-first bypass on registered reads, an optional hardwired zero register, and a sequenced clear-all operation with a busy flag.
- Sits between decode (register addresses) and ALU/memory stage (operand data), with write-back driving the write port.

---
 rtl/banco_registradores_param.sv | 143 ++++++++++++++
 tb/tb_banco_registradores_param.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/banco_registradores_param.sv
// Parametrised register file: two registered read ports with write-first
// bypass, optional hardwired zero register, and a sequenced clear-all sweep
// that raises Ocupado while it runs.

// One read port: computes the post-edge value of the addressed register
// (sweep clear beats write, zero register beats both) and registers it.
module banco_registradores_param_leitura #(
  parameter int LARGURA      = 8,
  parameter int PROFUNDIDADE = 8,
  parameter int END          = 3,
  parameter int ZERO_FIXO    = 0
) (
  input  logic                                   i_clock,
  input  logic                                   i_reset_n,
  input  logic [END-1:0]                         i_end,
  input  logic [PROFUNDIDADE-1:0][LARGURA-1:0]   i_br,
  input  logic                                   i_escreve,
  input  logic [END-1:0]                         i_end_escr,
  input  logic [LARGURA-1:0]                     i_dado_escr,
  input  logic                                   i_limpando,
  input  logic [END-1:0]                         i_indice,
  output logic [LARGURA-1:0]                     o_dado
);
  logic [LARGURA-1:0] w_prox;
  logic [LARGURA-1:0] r_dado;

  // Value the addressed register will hold after this edge.
  always_comb begin
    w_prox = i_br[i_end];
    if (i_limpando && (i_end == i_indice))
      w_prox = '0;
    else if (i_escreve && (i_end == i_end_escr))
      w_prox = i_dado_escr;
    if ((ZERO_FIXO != 0) && (i_end == '0))
      w_prox = '0;
  end

  // Registered read data.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_dado <= '0;
    else            r_dado <= w_prox;
  end

  assign o_dado = r_dado;
endmodule

module banco_registradores_param #(
  parameter int LARGURA      = 8,
  parameter int PROFUNDIDADE = 8,
  parameter int END          = $clog2(PROFUNDIDADE),
  parameter int ZERO_FIXO    = 0
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic [END-1:0]     RegLido1,
  input  logic [END-1:0]     RegLido2,
  input  logic [END-1:0]     RegEscr,
  input  logic [LARGURA-1:0] DadoEscr,
  input  logic               RegWrite,
  input  logic               Limpar,
  output logic [LARGURA-1:0] Dado1,
  output logic [LARGURA-1:0] Dado2,
  output logic               Ocupado
);
  localparam int               NUM_LEIT = 2;
  localparam logic [END-1:0]   ULTIMO   = END'(PROFUNDIDADE - 1);

  typedef enum logic {OCIOSO = 1'b0, LIMPANDO = 1'b1} estado_t;

  estado_t                              r_estado, w_prox_estado;
  logic [END-1:0]                       r_indice;
  logic [PROFUNDIDADE-1:0][LARGURA-1:0] r_br;
  logic                                 w_limpando;
  logic                                 w_escreve;
  logic [NUM_LEIT-1:0][END-1:0]         w_end_lido;
  logic [NUM_LEIT-1:0][LARGURA-1:0]     w_dado;

  // FSM state register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) r_estado <= OCIOSO;
    else          r_estado <= w_prox_estado;
  end

  // FSM next state: Limpar is only seen while idle, so no restart mid-sweep.
  always_comb begin
    w_prox_estado = r_estado;
    case (r_estado)
      OCIOSO:   if (Limpar)             w_prox_estado = LIMPANDO;
      LIMPANDO: if (r_indice == ULTIMO) w_prox_estado = OCIOSO;
      default:                          w_prox_estado = OCIOSO;
    endcase
  end

  // FSM outputs.
  always_comb begin
    w_limpando = (r_estado == LIMPANDO);
    Ocupado    = w_limpando;
  end

  // Sweep index; END-bit wrap back to 0 after the last register is intended.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)        r_indice <= '0;
    else if (w_limpando) r_indice <= r_indice + END'(1);
  end

  // A write is accepted only when idle and no clear is being requested;
  // writes to the hardwired zero register are dropped here.
  assign w_escreve = RegWrite && !w_limpando && !Limpar &&
                     !((ZERO_FIXO != 0) && (RegEscr == '0));

  // Register storage: sweep clear or normal write.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)        r_br           <= '0;
    else if (w_limpando) r_br[r_indice] <= '0;
    else if (w_escreve)  r_br[RegEscr]  <= DadoEscr;
  end

  assign w_end_lido[0] = RegLido1;
  assign w_end_lido[1] = RegLido2;

  for (genvar g = 0; g < NUM_LEIT; g++) begin : g_leitura
    banco_registradores_param_leitura #(
      .LARGURA      (LARGURA),
      .PROFUNDIDADE (PROFUNDIDADE),
      .END          (END),
      .ZERO_FIXO    (ZERO_FIXO)
    ) u_leitura (
      .i_clock     (Clock),
      .i_reset_n   (Reset_n),
      .i_end       (w_end_lido[g]),
      .i_br        (r_br),
      .i_escreve   (w_escreve),
      .i_end_escr  (RegEscr),
      .i_dado_escr (DadoEscr),
      .i_limpando  (w_limpando),
      .i_indice    (r_indice),
      .o_dado      (w_dado[g])
    );
  end

  assign Dado1 = w_dado[0];
  assign Dado2 = w_dado[1];
endmodule

// File: tb/tb_banco_registradores_param.sv
module tb_banco_registradores_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 8x8, no zero register
  logic       rst_n;
  logic [2:0] l1, l2, escr;
  logic [7:0] dado;
  logic       we, limpar;
  logic [7:0] d1, d2;
  logic       ocup;

  // Instance B: 16x32, hardwired zero register
  logic        b_rst_n;
  logic [4:0]  b_l1, b_l2, b_escr;
  logic [15:0] b_dado;
  logic        b_we, b_limpar;
  logic [15:0] b_d1, b_d2;
  logic        b_ocup;

  banco_registradores_param dut_a (
    .Clock(clk), .Reset_n(rst_n), .RegLido1(l1), .RegLido2(l2), .RegEscr(escr),
    .DadoEscr(dado), .RegWrite(we), .Limpar(limpar),
    .Dado1(d1), .Dado2(d2), .Ocupado(ocup));

  banco_registradores_param #(.LARGURA(16), .PROFUNDIDADE(32), .ZERO_FIXO(1)) dut_b (
    .Clock(clk), .Reset_n(b_rst_n), .RegLido1(b_l1), .RegLido2(b_l2), .RegEscr(b_escr),
    .DadoEscr(b_dado), .RegWrite(b_we), .Limpar(b_limpar),
    .Dado1(b_d1), .Dado2(b_d2), .Ocupado(b_ocup));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nome, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       we;
    logic [2:0] escr;
    logic [7:0] dado;
    logic [2:0] l1, l2;
    logic [7:0] e1, e2;
  } vec_t;

  localparam int NV = 19;
  vec_t tab[NV];

  initial begin
    // Table: write loop (reads bypass the write), read-back, bypass cases
    for (int i = 0; i < 8; i++)
      tab[i] = '{1'b1, 3'(i), 8'(i + 1), 3'(i), 3'(i), 8'(i + 1), 8'(i + 1)};
    for (int i = 0; i < 8; i++)
      tab[8 + i] = '{1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i), 8'(i + 1), 8'(8 - i)};
    tab[16] = '{1'b1, 3'd3, 8'h11, 3'd0, 3'd0, 8'h01, 8'h01};
    tab[17] = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd4, 8'hA5, 8'h05};
    tab[18] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 8'hA5, 8'hA5};

    rst_n = 1'b0; l1 = '0; l2 = '0; escr = '0; dado = '0; we = 1'b0; limpar = 1'b0;
    b_rst_n = 1'b0; b_l1 = '0; b_l2 = '0; b_escr = '0; b_dado = '0; b_we = 1'b0; b_limpar = 1'b0;
    tick(); tick();
    chk("reset_d1", 32'(d1), 0);
    chk("reset_d2", 32'(d2), 0);
    chk("reset_ocup", 32'(ocup), 0);
    rst_n = 1'b1; b_rst_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      we = tab[i].we; escr = tab[i].escr; dado = tab[i].dado;
      l1 = tab[i].l1; l2 = tab[i].l2;
      tick();
      chk($sformatf("vec%0d_d1", i), 32'(d1), 32'(tab[i].e1));
      chk($sformatf("vec%0d_d2", i), 32'(d2), 32'(tab[i].e2));
      chk($sformatf("vec%0d_ocup", i), 32'(ocup), 0);
    end
    we = 1'b0;

    // Clear sweep. BR = {1,2,3,A5,5,6,7,8}. Start edge carries a write that must drop.
    l1 = 3'd5; l2 = 3'd6;
    limpar = 1'b1; we = 1'b1; escr = 3'd5; dado = 8'hEE;
    tick();
    chk("sweep_start_ocup", 32'(ocup), 1);
    chk("sweep_start_d1", 32'(d1), 32'h06);
    limpar = 1'b0; we = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      we = (k == 2); escr = 3'd6; dado = 8'h77;   // write at sweep cycle 2: lost
      limpar = (k == 4);                           // no restart
      tick();
      chk($sformatf("sweep%0d_d1", k), 32'(d1), (k >= 6) ? 0 : 32'h06);
      chk($sformatf("sweep%0d_d2", k), 32'(d2), (k >= 7) ? 0 : 32'h07);
      chk($sformatf("sweep%0d_ocup", k), 32'(ocup), (k < 8) ? 1 : 0);
    end
    we = 1'b0; limpar = 1'b0;
    tick();
    chk("sweep_no_restart", 32'(ocup), 0);
    for (int i = 0; i < 8; i++) begin
      l1 = 3'(i); l2 = 3'(7 - i);
      tick();
      chk($sformatf("clr_rd%0d_d1", i), 32'(d1), 0);
      chk($sformatf("clr_rd%0d_d2", i), 32'(d2), 0);
    end

    // Zero-register instance
    b_we = 1'b1; b_escr = 5'd0; b_dado = 16'hBEEF; b_l1 = 5'd0; b_l2 = 5'd0;
    tick();
    chk("z_byp0_d1", 32'(b_d1), 0);
    chk("z_byp0_d2", 32'(b_d2), 0);
    b_escr = 5'd31; b_dado = 16'h1234; b_l1 = 5'd31; b_l2 = 5'd0;
    tick();
    chk("z_byp31_d1", 32'(b_d1), 32'h1234);
    chk("z_byp31_d2", 32'(b_d2), 0);
    b_we = 1'b0; b_l1 = 5'd0; b_l2 = 5'd31;
    tick();
    chk("z_rd0", 32'(b_d1), 0);
    chk("z_rd31", 32'(b_d2), 32'h1234);
    chk("z_ocup", 32'(b_ocup), 0);

    // Async reset mid-sweep
    we = 1'b1; escr = 3'd5; dado = 8'h55; tick();
    escr = 3'd2; dado = 8'h22; tick();
    we = 1'b0; l1 = 3'd5; l2 = 3'd2;
    limpar = 1'b1; tick();
    limpar = 1'b0;
    tick(); tick(); tick();          // sweep cycle 3: indices 0..2 cleared
    chk("pre_rst_d1", 32'(d1), 32'h55);
    chk("pre_rst_ocup", 32'(ocup), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_d1", 32'(d1), 0);
    chk("async_rst_d2", 32'(d2), 0);
    chk("async_rst_ocup", 32'(ocup), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_d1", 32'(d1), 0);
    chk("post_rst_d2", 32'(d2), 0);
    chk("post_rst_ocup", 32'(ocup), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
